// File: rtl/dac_fmt_pkg.sv
// Shared types for the DAC frame formatter.
//   dac_mode_t  : output word encoding selected per frame
//   fmt_state_t : serialiser FSM states
package dac_fmt_pkg;

  typedef enum logic [1:0] {
    TWOS       = 2'd0,
    OFFSET     = 2'd1,
    INV_OFFSET = 2'd2,
    MUTE       = 2'd3
  } dac_mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    OUT  = 1'b1
  } fmt_state_t;

endpackage

// File: rtl/dac_word_convert.sv
// Combinational saturate-and-encode of one signed sample into a DAC code.
//   sample : signed two's-complement input, IN_WIDTH bits
//   mode   : encoding select
//   code   : DAC_WIDTH-bit encoded word
module dac_word_convert
  import dac_fmt_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int DAC_WIDTH = 14
) (
  input  logic [IN_WIDTH-1:0]  sample,
  input  dac_mode_t            mode,
  output logic [DAC_WIDTH-1:0] code
);

  logic                 sign;
  logic                 fits;
  logic [DAC_WIDTH-1:0] sat;
  logic [DAC_WIDTH-1:0] ofs;

  // The sample fits in DAC_WIDTH signed bits when every bit from the DAC MSB
  // upward equals the sign; otherwise clamp to the extreme of that sign.
  assign sign = sample[IN_WIDTH-1];
  assign fits = (sample[IN_WIDTH-1:DAC_WIDTH-1] == {(IN_WIDTH-DAC_WIDTH+1){sign}});
  assign sat  = fits ? sample[DAC_WIDTH-1:0] : {sign, {(DAC_WIDTH-1){~sign}}};
  assign ofs  = {~sat[DAC_WIDTH-1], sat[DAC_WIDTH-2:0]};

  always_comb begin
    code = sat;
    case (mode)
      TWOS:       code = sat;
      OFFSET:     code = ofs;
      INV_OFFSET: code = ~ofs;   // (2^D-1) - ofs
      MUTE:       code = {1'b1, {(DAC_WIDTH-1){1'b0}}};
      default:    code = sat;
    endcase
  end

endmodule

// File: rtl/dac_frame_formatter.sv
// Accepts a frame of NUM_CH signed samples, converts each to a DAC code and
// serialises them onto one DAC bus, HOLD_CYCLES cycles per word.
//   clk, rst_n  : clock, async active-low reset
//   in_data     : frame, channel k at [k*IN_WIDTH +: IN_WIDTH]
//   in_valid    : frame valid; in_ready high only in IDLE
//   mode        : encoding select, captured with the frame
//   dac_data    : registered DAC code; holds last value when idle
//   dac_ch      : channel index of dac_data
//   dac_wr      : one-cycle strobe on the first cycle of each word
//   busy        : frame being output
//   frame_done  : one-cycle pulse after the last word's hold
module dac_frame_formatter
  import dac_fmt_pkg::*;
#(
  parameter  int IN_WIDTH    = 16,
  parameter  int DAC_WIDTH   = 14,
  parameter  int NUM_CH      = 4,
  parameter  int HOLD_CYCLES = 2,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int HOLD_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH*IN_WIDTH-1:0] in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 mode,
  output logic [DAC_WIDTH-1:0]       dac_data,
  output logic [CH_W-1:0]            dac_ch,
  output logic                       dac_wr,
  output logic                       busy,
  output logic                       frame_done
);

  logic [NUM_CH-1:0][DAC_WIDTH-1:0] cvt;
  logic [NUM_CH-1:0][DAC_WIDTH-1:0] words;
  fmt_state_t                       state;
  logic [HOLD_W-1:0]                hold;
  logic [CH_W-1:0]                  ch_nxt;

  // Conversion happens ahead of capture, so the frame is frozen (data and
  // mode) at acceptance and later input changes cannot reach it.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_cvt
    dac_word_convert #(
      .IN_WIDTH (IN_WIDTH),
      .DAC_WIDTH(DAC_WIDTH)
    ) u_cvt (
      .sample(in_data[k*IN_WIDTH +: IN_WIDTH]),
      .mode  (dac_mode_t'(mode)),
      .code  (cvt[k])
    );
  end

  assign in_ready = (state == IDLE);
  assign ch_nxt   = dac_ch + 1'b1;

  // dac_ch doubles as the channel counter: it only advances in OUT and
  // otherwise holds, which is exactly the idle behaviour wanted on the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      words      <= '0;
      hold       <= '0;
      dac_data   <= '0;
      dac_ch     <= '0;
      dac_wr     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      dac_wr     <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            // word0 goes straight to the bus so it appears one cycle after E0
            words    <= cvt;
            state    <= OUT;
            hold     <= '0;
            dac_data <= cvt[0];
            dac_ch   <= '0;
            dac_wr   <= 1'b1;
            busy     <= 1'b1;
          end
        end
        OUT: begin
          if (hold == HOLD_W'(HOLD_CYCLES-1)) begin
            if (dac_ch == CH_W'(NUM_CH-1)) begin
              state      <= IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              hold     <= '0;
              dac_ch   <= ch_nxt;
              dac_data <= words[ch_nxt];
              dac_wr   <= 1'b1;
            end
          end else begin
            hold <= hold + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
